// File: rtl/rob_if.sv
// Request-side and memory-side port groups of the
// reorder buffer, each with master/slave views.
interface rob_req_if #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int PWIDTH  = 8,
  parameter int IDWIDTH = 4
);
  logic               req_val;
  logic [AWIDTH-1:0]  req_addr;
  logic [IDWIDTH-1:0] req_ID;
  logic [PWIDTH-1:0]  req_param;
  logic               req_ready;
  logic               rsp_val;
  logic [DWIDTH-1:0]  rsp_data;
  logic [IDWIDTH-1:0] rsp_ID;
  logic [PWIDTH-1:0]  rsp_param;
  logic               rsp_ready;

  modport master (
    output req_val, req_addr, req_ID, req_param,
    output rsp_ready,
    input  req_ready,
    input  rsp_val, rsp_data, rsp_ID, rsp_param
  );

  modport slave (
    input  req_val, req_addr, req_ID, req_param,
    input  rsp_ready,
    output req_ready,
    output rsp_val, rsp_data, rsp_ID, rsp_param
  );
endinterface

interface rob_mem_if #(
  parameter int SWIDTH = 4,
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              mem_req_val;
  logic [AWIDTH-1:0] mem_req_addr;
  logic [SWIDTH-1:0] mem_req_ID;
  logic              mem_rsp_val;
  logic [SWIDTH-1:0] mem_rsp_ID;
  logic [DWIDTH-1:0] mem_rsp_data;

  modport master (
    output mem_req_val, mem_req_addr, mem_req_ID,
    input  mem_rsp_val, mem_rsp_ID, mem_rsp_data
  );

  modport slave (
    input  mem_req_val, mem_req_addr, mem_req_ID,
    output mem_rsp_val, mem_rsp_ID, mem_rsp_data
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: tags requests with their slot index,
// lets memory finish out of order, returns in order.
module rob #(
  parameter int ROB_SIZE = 16,
  parameter int SWIDTH   = 4,
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int PWIDTH   = 8,
  parameter int IDWIDTH  = 4
) (
  input  logic      clk,
  input  logic      rst_,
  rob_req_if.slave  req,
  rob_mem_if.master mem
);
  localparam logic [SWIDTH:0] FULL =
    (SWIDTH+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0] alloc;
  logic [ROB_SIZE-1:0] done;
  logic [IDWIDTH-1:0]  id_q  [ROB_SIZE];
  logic [PWIDTH-1:0]   par_q [ROB_SIZE];
  logic [DWIDTH-1:0]   dat_q [ROB_SIZE];
  logic [SWIDTH-1:0]   wr_ptr;
  logic [SWIDTH-1:0]   rd_ptr;
  logic [SWIDTH:0]     count;
  logic                acc;
  logic                pop;
  logic                fill;

  // Full blocks accepts even if the head pops this cycle.
  assign req.req_ready = rst_ && (count != FULL);
  assign req.rsp_val   = alloc[rd_ptr] && done[rd_ptr];

  // Payload is not reset, so force zeros while in reset.
  assign req.rsp_data  = rst_ ? dat_q[rd_ptr] : '0;
  assign req.rsp_ID    = rst_ ? id_q[rd_ptr]  : '0;
  assign req.rsp_param = rst_ ? par_q[rd_ptr] : '0;

  assign acc  = req.req_val && req.req_ready;
  assign pop  = req.rsp_val && req.rsp_ready;
  assign fill = mem.mem_rsp_val
             && alloc[mem.mem_rsp_ID]
             && !done[mem.mem_rsp_ID];

  // Circular pointers and occupancy.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (acc && !pop) count <= count + 1'b1;
      if (pop && !acc) count <= count - 1'b1;
    end
  end

  // Slot status; stale or duplicate completions are dropped.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      alloc <= '0;
      done  <= '0;
    end else begin
      if (fill) done[mem.mem_rsp_ID] <= 1'b1;
      if (pop) begin
        alloc[rd_ptr] <= 1'b0;
        done[rd_ptr]  <= 1'b0;
      end
      if (acc) begin
        alloc[wr_ptr] <= 1'b1;
        done[wr_ptr]  <= 1'b0;
      end
    end
  end

  // Slot payload storage.
  always_ff @(posedge clk) begin
    if (acc) begin
      id_q[wr_ptr]  <= req.req_ID;
      par_q[wr_ptr] <= req.req_param;
    end
    if (fill) dat_q[mem.mem_rsp_ID] <= mem.mem_rsp_data;
  end

  // One-cycle memory request pulse; addr/tag hold.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem.mem_req_val  <= 1'b0;
      mem.mem_req_addr <= '0;
      mem.mem_req_ID   <= '0;
    end else begin
      mem.mem_req_val <= acc;
      if (acc) begin
        mem.mem_req_addr <= req.req_addr;
        mem.mem_req_ID   <= wr_ptr;
      end
    end
  end
endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: random traffic against an
// out-of-order memory model and an in-order request queue.
module tb_rob;
  typedef struct {
    logic [3:0]  tag;
    logic [3:0]  id;
    logic [7:0]  par;
    logic [31:0] addr;
  } exp_t;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_acc = 0;

  exp_t       exp_q[$];
  int         pop_cyc[$];
  logic [3:0] frc_q[$];
  bit         frc = 1'b0;
  int         lat_lo = 0;
  int         lat_hi = 0;
  logic [3:0] s_tag = '0;

  bit          pend[16];
  int          due[16];
  logic [31:0] paddr[16];
  int          rsp_cyc[16];
  logic [3:0]  m_tag = '0;

  rob_req_if q ();
  rob_mem_if m ();

  rob dut (
    .clk  (clk),
    .rst_ (rst_),
    .req  (q),
    .mem  (m)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EEDC0DE;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: records tagged requests, completes them
  // after a random latency or in a forced tag order.
  always @(negedge clk) begin : mem_p
    int t;
    int off;
    #1;
    m.mem_rsp_val = 1'b0;
    if (!rst_) begin
      for (int i = 0; i < 16; i++) pend[i] = 1'b0;
      m_tag = '0;
      frc_q.delete();
      m.mem_rsp_ID = '0;
      m.mem_rsp_data = '0;
    end else begin
      if (m.mem_req_val) begin
        chk("mem_req_ID", m.mem_req_ID, m_tag);
        chk("tag_free", pend[m.mem_req_ID], 0);
        pend[m.mem_req_ID] = 1'b1;
        paddr[m.mem_req_ID] = m.mem_req_addr;
        due[m.mem_req_ID] =
          cyc + int'($urandom_range(lat_hi, lat_lo));
        m_tag = m_tag + 1'b1;
      end
      t = -1;
      if (frc) begin
        if (frc_q.size() != 0 && pend[frc_q[0]]) begin
          t = int'(frc_q.pop_front());
        end
      end else begin
        off = int'($urandom_range(15, 0));
        for (int k = 0; k < 16; k++) begin
          if (t < 0 && pend[(off + k) % 16]
              && due[(off + k) % 16] <= cyc)
            t = (off + k) % 16;
        end
      end
      if (t >= 0) begin
        m.mem_rsp_val = 1'b1;
        m.mem_rsp_ID = 4'(t);
        m.mem_rsp_data = fdat(paddr[t]);
        pend[t] = 1'b0;
        rsp_cyc[t] = cyc;
      end
    end
  end

  // Monitor: pops the expected queue on every response.
  always @(negedge clk) begin : mon_p
    exp_t e;
    logic h_v;
    logic [31:0] h_d;
    logic [3:0] h_i;
    #2;
    if (!rst_) begin
      exp_q.delete();
      h_v = 1'b0;
    end else begin
      if (h_v) begin
        chk("hold_val", q.rsp_val, 1);
        chk("hold_data", q.rsp_data, h_d);
        chk("hold_ID", q.rsp_ID, h_i);
      end
      if (q.rsp_val && q.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_extra: got ID %0h, expected none",
                   q.rsp_ID);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_ID", q.rsp_ID, e.id);
          chk("rsp_param", q.rsp_param, e.par);
          chk("rsp_data", q.rsp_data, fdat(e.addr));
          pop_cyc.push_back(cyc);
        end
      end
      h_v = q.rsp_val && !q.rsp_ready;
      h_d = q.rsp_data;
      h_i = q.rsp_ID;
    end
  end

  task automatic record();
    if (q.req_val && q.req_ready) begin
      exp_q.push_back('{tag: s_tag, id: q.req_ID,
                        par: q.req_param, addr: q.req_addr});
      s_tag = s_tag + 1'b1;
      n_acc++;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [3:0] id, input logic [7:0] p,
                       input logic rr);
    @(negedge clk);
    q.req_val = v;
    q.req_addr = a;
    q.req_ID = id;
    q.req_param = p;
    q.rsp_ready = rr;
    #1;
    record();
  endtask

  task automatic rnd(input logic rr);
    drive(1'b1, $urandom, 4'($urandom), 8'($urandom), rr);
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      drive(1'b0, '0, '0, '0, 1'b1);
      #2;
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_rsp(input logic rr, input string nm);
    int k;
    k = 0;
    do begin
      drive(1'b0, '0, '0, '0, rr);
      k++;
    end while (!q.rsp_val && k < 20);
    chk(nm, q.rsp_val, 1);
  endtask

  initial begin : stim
    int base;
    int k;
    bit got;
    logic [3:0] b;
    q.req_val = 1'b0;
    q.req_addr = '0;
    q.req_ID = '0;
    q.req_param = '0;
    q.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", q.req_ready, 0);
    chk("rst_rsp_val", q.rsp_val, 0);
    chk("rst_mem_val", m.mem_req_val, 0);
    chk("rst_mem_addr", m.mem_req_addr, 0);
    chk("rst_mem_ID", m.mem_req_ID, 0);
    chk("rst_rsp_data", q.rsp_data, 0);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    chk("ready_first", q.req_ready, 1);

    // single request, fixed latency 3
    lat_lo = 3;
    lat_hi = 3;
    drive(1'b1, 32'h100, 4'd3, 8'h5A, 1'b1);
    drain(20);

    // minimum latency: rsp_val two cycles after accept
    lat_lo = 0;
    lat_hi = 0;
    drive(1'b1, 32'h200, 4'd1, 8'h11, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1);
    #2;
    chk("min_lat_early", q.rsp_val, 0);
    drive(1'b0, '0, '0, '0, 1'b1);
    chk("min_lat", q.rsp_val, 1);
    drain(10);

    // four requests completed 3,1,2,0
    frc = 1'b1;
    b = s_tag;
    for (int i = 0; i < 4; i++)
      drive(1'b1, $urandom, 4'(i), 8'($urandom), 1'b1);
    repeat (2) drive(1'b0, '0, '0, '0, 1'b1);
    pop_cyc.delete();
    frc_q.push_back(b + 4'd3);
    frc_q.push_back(b + 4'd1);
    frc_q.push_back(b + 4'd2);
    frc_q.push_back(b);
    drain(30);
    chk("ord_pops", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      chk("ord_first", pop_cyc[0], rsp_cyc[b] + 1);
      for (int i = 1; i < 4; i++)
        chk("ord_consec", pop_cyc[i], pop_cyc[0] + i);
    end

    // eight pending, then accept and pop together
    for (int i = 0; i < 8; i++) rnd(1'b1);
    frc_q.push_back(exp_q[0].tag);
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      q.req_val = 1'b0;
      q.rsp_ready = 1'b1;
      #1;
      if (q.rsp_val) begin
        chk("swap_ready", q.req_ready, 1);
        q.req_val = 1'b1;
        q.req_addr = $urandom;
        q.req_ID = 4'($urandom);
        q.req_param = 8'($urandom);
        record();
        got = 1'b1;
      end
      k++;
    end
    chk("swap_seen", got, 1);

    // refill: exactly eight more accepts fit
    base = n_acc;
    k = 0;
    do begin
      rnd(1'b1);
      k++;
    end while (q.req_ready && k < 30);
    chk("refill_count", n_acc - base, 8);
    chk("full_ready", q.req_ready, 0);
    chk("full_pending", exp_q.size(), 16);

    // full: pop does not free the slot same cycle
    frc_q.push_back(exp_q[0].tag);
    k = 0;
    do begin
      rnd(1'b1);
      k++;
    end while (!q.rsp_val && k < 20);
    chk("no_push_through", q.req_ready, 0);
    rnd(1'b1);
    chk("ready_after_pop", q.req_ready, 1);
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      frc_q.push_back(exp_q[i].tag);
    drain(60);

    // random traffic with backpressure
    frc = 1'b0;
    lat_lo = 0;
    lat_hi = 20;
    base = n_acc;
    k = 0;
    while (n_acc - base < 10000 && k < 60000) begin
      drive($urandom_range(9, 0) < 7, $urandom,
            4'($urandom), 8'($urandom),
            $urandom_range(9, 0) < 6);
      k++;
    end
    chk("rand_count", n_acc - base, 10000);
    drain(2000);

    // mid-stream reset with five entries pending
    frc = 1'b1;
    for (int i = 0; i < 4; i++) rnd(1'b0);
    frc_q.push_back(exp_q[0].tag);
    wait_rsp(1'b0, "pre_rst_rsp");
    rnd(1'b0);
    chk("pre_rst_pending", exp_q.size(), 5);
    @(negedge clk);
    rst_ = 1'b0;
    q.req_val = 1'b0;
    #1;
    chk("mid_rst_rsp_val", q.rsp_val, 0);
    chk("mid_rst_mem_val", m.mem_req_val, 0);
    chk("mid_rst_ready", q.req_ready, 0);
    chk("mid_rst_rsp_ID", q.rsp_ID, 0);
    chk("mid_rst_rsp_par", q.rsp_param, 0);
    s_tag = '0;
    repeat (3) drive(1'b0, '0, '0, '0, 1'b1);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    chk("ready_after_rst", q.req_ready, 1);
    chk("rsp_after_rst", q.rsp_val, 0);
    frc = 1'b0;
    lat_lo = 0;
    lat_hi = 5;
    for (int i = 0; i < 6; i++) rnd(1'b1);
    drive(1'b0, '0, '0, '0, 1'b1);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
